// File: rtl/host_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : host_bus_master
// Description : TI-99/4A expansion-bus cycle initiator. Turns 16-bit word
//               requests into two multiplexed 8-bit host cycles (odd byte
//               first) aligned to a free-running phi3, and emulates the two
//               8-bit PISO address shift registers read back over
//               shld/serclk on adrin1/adrin2.
// Revision    : 1.0 - initial release
// ============================================================================
module host_bus_master #(
    parameter int PHI_PERIOD = 8,
    parameter int ADDR_CLKS  = 24,
    parameter int BYTE_CLKS  = 8,
    parameter int WE_CLKS    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        phi3,
    output logic        memen,
    output logic        dbin,
    output logic        we,
    output logic        a15,
    output logic [7:0]  data_bus_out,
    output logic        data_bus_oe,
    input  logic [7:0]  data_bus_in,
    input  logic        shld,
    input  logic        serclk,
    output logic        adrin1,
    output logic        adrin2
);

    localparam int PC_W       = $clog2(PHI_PERIOD);
    localparam int CNT_MAX_AB = (ADDR_CLKS > BYTE_CLKS) ? ADDR_CLKS : BYTE_CLKS;
    localparam int CNT_MAX    = (CNT_MAX_AB > PHI_PERIOD) ? CNT_MAX_AB : PHI_PERIOD;
    localparam int CNT_W      = $clog2(CNT_MAX);

    localparam logic [PC_W-1:0]  PC_LAST   = PC_W'(PHI_PERIOD - 1);
    localparam logic [PC_W-1:0]  PC_HALF   = PC_W'(PHI_PERIOD / 2);
    localparam logic [PC_W-1:0]  PC_ONE    = PC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_CLKS - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(BYTE_CLKS - 1);
    localparam logic [CNT_W-1:0] END_LAST  = CNT_W'(PHI_PERIOD - 1);
    localparam logic [CNT_W-1:0] WE_LAST   = CNT_W'(WE_CLKS);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC      = 3'd1,
        ST_ADDR      = 3'd2,
        ST_BYTE_ODD  = 3'd3,
        ST_BYTE_EVEN = 3'd4,
        ST_END       = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               pc_wrap;
    logic               accept;
    logic               ready_q;
    logic               write_q;
    logic [15:0]        addr_q;
    logic [15:0]        wdata_q;
    logic [15:0]        rdata_q;
    logic [15:0]        rsp_rdata_q;
    logic [7:0]         sr1_q, sr2_q;
    logic               serclk_q;
    logic               in_byte;
    logic               last_byte_clk;
    logic               unused_addr_lsb;

    // Byte address bit 0 is meaningless on a word bus.
    assign unused_addr_lsb = req_addr[0];

    assign pc_wrap = (pc_q == PC_LAST);
    assign pc_d    = pc_wrap ? '0 : (pc_q + PC_ONE);

    assign in_byte       = (state_q == ST_BYTE_ODD) || (state_q == ST_BYTE_EVEN);
    assign last_byte_clk = in_byte && (cnt_q == BYTE_LAST);

    // Free-running phi3 phase counter; phi3 falls when it wraps to 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    // FSM state and phase counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and bus-cycle output decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        memen        = 1'b1;
        dbin         = 1'b0;
        we           = 1'b0;
        a15          = 1'b0;
        data_bus_out = 8'h00;
        data_bus_oe  = 1'b0;
        rsp_valid    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                // Align the memen fall with a phi3 fall.
                if (pc_wrap) begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
            end
            ST_ADDR: begin
                memen = 1'b0;
                dbin  = !write_q;
                a15   = 1'b1;
                if (cnt_q == ADDR_LAST) begin
                    state_d = ST_BYTE_ODD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_BYTE_ODD, ST_BYTE_EVEN: begin
                memen = 1'b0;
                dbin  = !write_q;
                a15   = (state_q == ST_BYTE_ODD);
                if (write_q) begin
                    data_bus_oe  = 1'b1;
                    data_bus_out = (state_q == ST_BYTE_ODD) ? wdata_q[7:0] : wdata_q[15:8];
                    // Strobe starts one clk into the phase so a15 is settled.
                    we = (cnt_q >= CNT_ONE) && (cnt_q <= WE_LAST);
                end
                if (cnt_q == BYTE_LAST) begin
                    state_d = (state_q == ST_BYTE_ODD) ? ST_BYTE_EVEN : ST_END;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_END: begin
                rsp_valid = (cnt_q == '0);
                // One full phi3 period of bus idle before the next request.
                if (cnt_q == END_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Request latch, read-byte capture and response data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready_q     <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            rsp_rdata_q <= 16'h0000;
        end else begin
            ready_q <= (state_d == ST_IDLE);
            if (accept) begin
                write_q <= req_write;
                addr_q  <= {req_addr[15:1], 1'b0};
                wdata_q <= req_wdata;
            end
            if (last_byte_clk && !write_q) begin
                if (state_q == ST_BYTE_ODD) begin
                    rdata_q[7:0] <= data_bus_in;
                end else begin
                    rdata_q[15:8] <= data_bus_in;
                    // Publish the completed word on the same edge END begins.
                    rsp_rdata_q   <= {data_bus_in, rdata_q[7:0]};
                end
            end
        end
    end

    // Address PISO emulation: load has priority over a serclk rising edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr1_q    <= 8'h00;
            sr2_q    <= 8'h00;
            serclk_q <= 1'b0;
        end else begin
            serclk_q <= serclk;
            if (!shld) begin
                sr1_q <= addr_q[15:8];
                sr2_q <= addr_q[7:0];
            end else if (serclk && !serclk_q) begin
                sr1_q <= {sr1_q[6:0], 1'b0};
                sr2_q <= {sr2_q[6:0], 1'b0};
            end
        end
    end

    assign phi3      = (pc_q >= PC_HALF);
    assign req_ready = ready_q;
    assign rsp_rdata = rsp_rdata_q;
    assign adrin1    = sr1_q[7];
    assign adrin2    = sr2_q[7];

endmodule
`default_nettype wire

// File: tb/tb_host_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_bus_master
// Description : Directed self-checking bench for host_bus_master.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_host_bus_master;

    localparam int PHI_PERIOD = 8;
    localparam int ADDR_CLKS  = 24;
    localparam int BYTE_CLKS  = 8;
    localparam int WE_CLKS    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [15:0] req_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        phi3, memen, dbin, we, a15;
    logic [7:0]  data_bus_out;
    logic        data_bus_oe;
    logic [7:0]  data_bus_in;
    logic        shld = 1'b1;
    logic        serclk = 1'b0;
    logic        adrin1, adrin2;

    int n_assert = 0;
    int n_fail   = 0;

    // Monitor bookkeeping
    int          cyc = 0;
    int          n_acc, n_rsp, n_fall, n_rise;
    int          acc_cyc [2];
    int          rsp_cyc [2];
    int          fall_cyc[2];
    int          rise_cyc[2];
    logic        memen_at_acc[2];
    int          n_we_odd, n_we_even, n_oe_odd, n_oe_even;
    int          n_dout_bad, n_dbin_bad, n_a15_we_bad, n_misalign;
    logic [15:0] last_rdata;
    logic        exp_dbin = 1'b0;
    logic [7:0]  exp_odd = 8'h00, exp_even = 8'h00;
    logic        p_ready = 1'b0, p_memen = 1'b1, p_phi3 = 1'b0, p_a15 = 1'b0, p_we = 1'b0;

    host_bus_master #(
        .PHI_PERIOD (PHI_PERIOD),
        .ADDR_CLKS  (ADDR_CLKS),
        .BYTE_CLKS  (BYTE_CLKS),
        .WE_CLKS    (WE_CLKS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .phi3         (phi3),
        .memen        (memen),
        .dbin         (dbin),
        .we           (we),
        .a15          (a15),
        .data_bus_out (data_bus_out),
        .data_bus_oe  (data_bus_oe),
        .data_bus_in  (data_bus_in),
        .shld         (shld),
        .serclk       (serclk),
        .adrin1       (adrin1),
        .adrin2       (adrin2)
    );

    always #5 clk = ~clk;

    // Responder: odd byte 0x34, even byte 0x12.
    assign data_bus_in = a15 ? 8'h34 : 8'h12;

    // Bus monitor, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (req_valid && p_ready) begin
            if (n_acc < 2) begin
                acc_cyc[n_acc]      = cyc - 1;
                memen_at_acc[n_acc] = p_memen;
            end
            n_acc++;
        end
        if (rsp_valid) begin
            if (n_rsp < 2) rsp_cyc[n_rsp] = cyc;
            last_rdata = rsp_rdata;
            n_rsp++;
        end
        if (p_memen && !memen) begin
            if (n_fall < 2) fall_cyc[n_fall] = cyc;
            n_fall++;
            if (!(p_phi3 && !phi3)) n_misalign++;
        end
        if (!p_memen && memen) begin
            if (n_rise < 2) rise_cyc[n_rise] = cyc;
            n_rise++;
        end
        if (!memen && (dbin !== exp_dbin)) n_dbin_bad++;
        if (we) begin
            if (a15) n_we_odd++;
            else     n_we_even++;
        end
        if (data_bus_oe) begin
            if (a15) begin
                n_oe_odd++;
                if (data_bus_out !== exp_odd) n_dout_bad++;
            end else begin
                n_oe_even++;
                if (data_bus_out !== exp_even) n_dout_bad++;
            end
        end
        if ((a15 !== p_a15) && (we || p_we)) n_a15_we_bad++;
        p_ready = req_ready;
        p_memen = memen;
        p_phi3  = phi3;
        p_a15   = a15;
        p_we    = we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        n_acc = 0; n_rsp = 0; n_fall = 0; n_rise = 0;
        n_we_odd = 0; n_we_even = 0; n_oe_odd = 0; n_oe_even = 0;
        n_dout_bad = 0; n_dbin_bad = 0; n_a15_we_bad = 0; n_misalign = 0;
    endtask

    // Present a request and drop req_valid once it has been accepted.
    task automatic start_req(input string tag, input logic w, input logic [15:0] a,
                             input logic [15:0] d);
        int n0;
        bit ok;
        @(negedge clk);
        n0 = n_acc;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (n_acc > n0) begin
                ok = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        chk({tag, "_accept_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input string tag, input int target);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (n_rsp >= target) begin
                ok = 1'b1;
                break;
            end
        end
        chk({tag, "_rsp_timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic shift_rise();
        @(negedge clk); serclk = 1'b1;
        @(negedge clk); serclk = 1'b0;
    endtask

    logic [7:0] sa1, sa2;
    bit         seen;

    initial begin
        clear_mon();

        // ---------------- Reset values ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_memen",   32'(memen),        32'd1);
        chk("rst_dbin",    32'(dbin),         32'd0);
        chk("rst_we",      32'(we),           32'd0);
        chk("rst_a15",     32'(a15),          32'd0);
        chk("rst_phi3",    32'(phi3),         32'd0);
        chk("rst_dout",    32'(data_bus_out), 32'h00);
        chk("rst_oe",      32'(data_bus_oe),  32'd0);
        chk("rst_adrin1",  32'(adrin1),       32'd0);
        chk("rst_adrin2",  32'(adrin2),       32'd0);
        chk("rst_ready",   32'(req_ready),    32'd0);
        chk("rst_rspv",    32'(rsp_valid),    32'd0);
        chk("rst_rdata",   32'(rsp_rdata),    32'h0000);
        reset = 1'b1;
        chk("rel_ready_0", 32'(req_ready),    32'd0);
        @(negedge clk);
        chk("rel_ready_1", 32'(req_ready),    32'd1);

        // ---------------- Read 0x6000 ----------------
        clear_mon();
        exp_dbin = 1'b1;
        start_req("rd", 1'b0, 16'h6000, 16'h0000);
        wait_rsp("rd", 1);
        repeat (PHI_PERIOD + 4) @(negedge clk);
        chk("rd_rsp_count", 32'(n_rsp),         32'd1);
        chk("rd_rdata",     32'(last_rdata),    32'h1234);
        chk("rd_rdata_hold",32'(rsp_rdata),     32'h1234);
        chk("rd_dbin",      32'(n_dbin_bad),    32'd0);
        chk("rd_we_never",  32'(n_we_odd + n_we_even), 32'd0);
        chk("rd_oe_never",  32'(n_oe_odd + n_oe_even), 32'd0);
        chk("rd_phi_align", 32'(n_misalign),    32'd0);
        chk("rd_lat_body",  32'(rsp_cyc[0] - fall_cyc[0]), 32'(ADDR_CLKS + 2 * BYTE_CLKS));
        chk("rd_lat_sync",  32'((fall_cyc[0] - acc_cyc[0] >= 2) &&
                                (fall_cyc[0] - acc_cyc[0] <= PHI_PERIOD + 1)), 32'd1);

        // ---------------- Write 0xA000 / 0xBEEF ----------------
        clear_mon();
        exp_dbin = 1'b0;
        exp_odd  = 8'hEF;
        exp_even = 8'hBE;
        start_req("wr", 1'b1, 16'hA000, 16'hBEEF);
        wait_rsp("wr", 1);
        repeat (PHI_PERIOD + 4) @(negedge clk);
        chk("wr_rsp_count", 32'(n_rsp),        32'd1);
        chk("wr_we_odd",    32'(n_we_odd),     32'(WE_CLKS));
        chk("wr_we_even",   32'(n_we_even),    32'(WE_CLKS));
        chk("wr_oe_odd",    32'(n_oe_odd),     32'(BYTE_CLKS));
        chk("wr_oe_even",   32'(n_oe_even),    32'(BYTE_CLKS));
        chk("wr_dout",      32'(n_dout_bad),   32'd0);
        chk("wr_dbin",      32'(n_dbin_bad),   32'd0);
        chk("wr_a15_we",    32'(n_a15_we_bad), 32'd0);
        chk("wr_rdata_keep",32'(rsp_rdata),    32'h1234);
        chk("wr_oe_idle",   32'(data_bus_oe),  32'd0);

        // ---------------- Serial address 0xA05C ----------------
        clear_mon();
        exp_dbin = 1'b1;
        start_req("sa", 1'b0, 16'hA05C, 16'h0000);
        wait_rsp("sa", 1);
        repeat (PHI_PERIOD + 4) @(negedge clk);
        chk("sa_rdata", 32'(rsp_rdata), 32'h1234);
        sa1 = 8'hA0;
        sa2 = 8'h5C;
        @(negedge clk); shld = 1'b0;
        @(negedge clk); shld = 1'b1;
        chk("sa_bit0_a1", 32'(adrin1), 32'(sa1[7]));
        chk("sa_bit0_a2", 32'(adrin2), 32'(sa2[7]));
        for (int i = 1; i < 8; i++) begin
            shift_rise();
            chk($sformatf("sa_bit%0d_a1", i), 32'(adrin1), 32'(sa1[7-i]));
            chk($sformatf("sa_bit%0d_a2", i), 32'(adrin2), 32'(sa2[7-i]));
        end
        shift_rise();
        chk("sa_empty_a1", 32'(adrin1), 32'd0);
        chk("sa_empty_a2", 32'(adrin2), 32'd0);
        shift_rise();
        chk("sa_empty2_a1", 32'({adrin1, adrin2}), 32'd0);
        // Load and a serclk rise on the same clk: load wins.
        @(negedge clk); shld = 1'b0; serclk = 1'b1;
        @(negedge clk); shld = 1'b1; serclk = 1'b0;
        chk("sa_loadwin_a1", 32'(adrin1), 32'd1);
        chk("sa_loadwin_a2", 32'(adrin2), 32'd0);
        shift_rise();
        chk("sa_after_a1", 32'(adrin1), 32'd0);
        chk("sa_after_a2", 32'(adrin2), 32'd1);

        // ---------------- Back-to-back reads ----------------
        clear_mon();
        exp_dbin = 1'b1;
        @(negedge clk);
        req_write = 1'b0; req_addr = 16'h6000; req_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (n_acc >= 2) begin
                seen = 1'b1;
                break;
            end
        end
        req_valid = 1'b0;
        chk("b2b_accept_timeout", 32'(seen), 32'd1);
        wait_rsp("b2b", 2);
        repeat (PHI_PERIOD + 4) @(negedge clk);
        chk("b2b_acc_count",  32'(n_acc),   32'd2);
        chk("b2b_rsp_count",  32'(n_rsp),   32'd2);
        chk("b2b_gap",        32'(acc_cyc[1] - rsp_cyc[0]), 32'(PHI_PERIOD));
        chk("b2b_rise",       32'(rise_cyc[0]), 32'(rsp_cyc[0]));
        chk("b2b_memen_acc2", 32'(memen_at_acc[1]), 32'd1);
        chk("b2b_falls",      32'(n_fall),  32'd2);
        chk("b2b_phi_align",  32'(n_misalign), 32'd0);
        chk("b2b_lat2",       32'(rsp_cyc[1] - fall_cyc[1]), 32'(ADDR_CLKS + 2 * BYTE_CLKS));
        chk("b2b_dbin",       32'(n_dbin_bad), 32'd0);

        // ---------------- Reset during BYTE_EVEN of a write ----------------
        clear_mon();
        exp_dbin = 1'b0;
        exp_odd  = 8'h78;
        exp_even = 8'h56;
        start_req("mr", 1'b1, 16'h1234, 16'h5678);
        seen = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (we && !a15 && !memen) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mr_even_timeout", 32'(seen), 32'd1);
        reset = 1'b0;
        @(negedge clk);
        chk("mr_memen", 32'(memen),       32'd1);
        chk("mr_we",    32'(we),          32'd0);
        chk("mr_oe",    32'(data_bus_oe), 32'd0);
        chk("mr_ready", 32'(req_ready),   32'd0);
        reset = 1'b1;
        repeat (60) @(negedge clk);
        chk("mr_no_rsp",   32'(n_rsp),     32'd0);
        chk("mr_no_refall",32'(n_fall),    32'd1);
        chk("mr_idle_rdy", 32'(req_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
